// File: rtl/sigma_xif_periph_if.sv
// xif request/response bundle between the core tile and a memory-mapped slave.
// Request side: req, we, addr, be, wdata (driven by master).
// Response side: ack (same-cycle accept), resp/rdata (one cycle after an accepted read).
interface sigma_xif_periph_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ack;
    logic        resp;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  ack, resp, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output ack, resp, rdata
    );
endinterface

// File: rtl/sigma_xif_periph.sv
// LED/switch/timer peripheral on the xif bus with a level interrupt.
// Latency: ack is combinational; resp/rdata follow an accepted read by one cycle.
// Backpressure: none, every in-window request is accepted immediately.
// Ports: clk_i/rst_n_i (sync active-low), bus (xif slave), gpio_bi (async switches),
//        gpio_bo (LED register), irq_o (timer expiry & IE).
module sigma_xif_periph #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int unsigned PRESCALE  = 1,
    parameter logic [31:0] LED_RST   = 32'h0
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    sigma_xif_periph_if.slave     bus,
    input  logic [31:0]           gpio_bi,
    output logic [31:0]           gpio_bo,
    output logic                  irq_o
);

    localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

    localparam logic [5:0] OFF_LED    = 6'h00;
    localparam logic [5:0] OFF_SW     = 6'h01;
    localparam logic [5:0] OFF_CTRL   = 6'h02;
    localparam logic [5:0] OFF_PERIOD = 6'h03;
    localparam logic [5:0] OFF_VALUE  = 6'h04;
    localparam logic [5:0] OFF_STATUS = 6'h05;

    logic        in_window;
    logic        wr_acc;
    logic        rd_acc;
    logic [5:0]  off;

    logic [31:0] led_q;
    logic [31:0] sw_meta;
    logic [31:0] sw_sync;
    logic        ctrl_en;
    logic        ctrl_auto;
    logic        ctrl_ie;
    logic [31:0] period_q;
    logic [31:0] value_q;
    logic [15:0] pre_q;
    logic        exp_q;
    logic        resp_q;
    logic [31:0] rdata_q;

    logic [31:0] rd_dat;
    logic        tick;
    logic        expire;
    logic        ctrl_wr;
    logic        start;
    logic        sts_clr;

    function automatic logic [31:0] be_merge(input logic [31:0] old,
                                             input logic [31:0] wd,
                                             input logic [3:0]  be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    assign in_window = (bus.addr[31:8] == BASE_ADDR[31:8]);
    assign bus.ack   = bus.req & in_window;
    assign wr_acc    = bus.ack & bus.we;
    assign rd_acc    = bus.ack & ~bus.we;
    assign off       = bus.addr[7:2];

    always_comb begin
        rd_dat = '0;
        case (off)
            OFF_LED:    rd_dat = led_q;
            OFF_SW:     rd_dat = sw_sync;
            OFF_CTRL:   rd_dat = {29'd0, ctrl_ie, ctrl_auto, ctrl_en};
            OFF_PERIOD: rd_dat = period_q;
            OFF_VALUE:  rd_dat = value_q;
            OFF_STATUS: rd_dat = {31'd0, exp_q};
            default:    rd_dat = '0;
        endcase
    end

    // PERIOD==0 never matches, so the counter is held at 0 while running.
    assign tick    = ctrl_en && (pre_q == PRE_LAST);
    assign expire  = tick && (period_q != 32'd0) && (value_q == period_q - 32'd1);
    assign ctrl_wr = wr_acc && (off == OFF_CTRL) && bus.be[0];
    // Only a 0->1 transition of EN restarts the count; 1->1 leaves it running.
    assign start   = ctrl_wr && bus.wdata[0] && !ctrl_en;
    assign sts_clr = wr_acc && (off == OFF_STATUS) && bus.be[0] && bus.wdata[0];

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            led_q     <= LED_RST;
            sw_meta   <= '0;
            sw_sync   <= '0;
            ctrl_en   <= 1'b0;
            ctrl_auto <= 1'b0;
            ctrl_ie   <= 1'b0;
            period_q  <= '0;
            value_q   <= '0;
            pre_q     <= '0;
            exp_q     <= 1'b0;
            resp_q    <= 1'b0;
            rdata_q   <= '0;
        end else begin
            resp_q  <= rd_acc;
            rdata_q <= rd_acc ? rd_dat : 32'd0;

            sw_meta <= gpio_bi;
            sw_sync <= sw_meta;

            if (wr_acc && off == OFF_LED)    led_q    <= be_merge(led_q, bus.wdata, bus.be);
            if (wr_acc && off == OFF_PERIOD) period_q <= be_merge(period_q, bus.wdata, bus.be);

            if (start) begin
                pre_q   <= '0;
                value_q <= '0;
            end else if (ctrl_en) begin
                pre_q <= tick ? 16'd0 : pre_q + 16'd1;
                if (tick && period_q != 32'd0) begin
                    if (expire) value_q <= ctrl_auto ? 32'd0 : period_q;
                    else        value_q <= value_q + 32'd1;
                end
            end

            // A software CTRL write overrides the one-shot self-disable.
            if (ctrl_wr) begin
                ctrl_en   <= bus.wdata[0];
                ctrl_auto <= bus.wdata[1];
                ctrl_ie   <= bus.wdata[2];
            end else if (expire && !ctrl_auto) begin
                ctrl_en <= 1'b0;
            end

            // Expiry beats a same-cycle clear so no event is lost.
            if (expire)       exp_q <= 1'b1;
            else if (sts_clr) exp_q <= 1'b0;
        end
    end

    assign bus.resp  = resp_q;
    assign bus.rdata = rdata_q;
    assign gpio_bo   = led_q;
    assign irq_o     = exp_q & ctrl_ie;

endmodule

// File: tb/tb_sigma_xif_periph.sv
module tb_sigma_xif_periph;

    localparam logic [31:0] BASE     = 32'h8000_0000;
    localparam int          PRESCALE = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] gpio_in;
    logic [31:0] gpio_out;
    logic        irq;

    sigma_xif_periph_if bus ();

    sigma_xif_periph #(
        .BASE_ADDR (BASE),
        .PRESCALE  (PRESCALE),
        .LED_RST   (32'h0)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus),
        .gpio_bi (gpio_in),
        .gpio_bo (gpio_out),
        .irq_o   (irq)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model (register-level behaviour) ----------------
    logic [31:0] m_led, m_sw1, m_sw2, m_period, m_value, m_rdata;
    logic        m_en, m_auto, m_ie, m_exp, m_resp;
    int          m_pre;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = w[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_read(input logic [7:0] a);
        case (a & 8'hFC)
            8'h00:   return m_led;
            8'h04:   return m_sw2;
            8'h08:   return {29'd0, m_ie, m_auto, m_en};
            8'h0C:   return m_period;
            8'h10:   return m_value;
            8'h14:   return {31'd0, m_exp};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step(input logic rst, input logic req, input logic we,
                              input logic [31:0] addr, input logic [3:0] be,
                              input logic [31:0] wd, input logic [31:0] gpio);
        logic        hit, expire, en_old;
        logic [7:0]  off;
        if (!rst) begin
            m_led = 0; m_sw1 = 0; m_sw2 = 0; m_period = 0; m_value = 0;
            m_en = 0; m_auto = 0; m_ie = 0; m_exp = 0; m_pre = 0;
            m_resp = 0; m_rdata = 0;
            return;
        end
        hit    = req && (addr[31:8] == BASE[31:8]);
        off    = addr[7:0] & 8'hFC;
        m_rdata = (hit && !we) ? m_read(addr[7:0]) : 32'd0;
        m_resp  = hit && !we;
        expire = 1'b0;
        en_old = m_en;
        if (m_en) begin
            m_pre = m_pre + 1;
            if (m_pre == PRESCALE) begin
                m_pre = 0;
                if (m_period != 0) begin
                    if (m_value == m_period - 1) begin
                        expire = 1'b1;
                        if (m_auto) m_value = 0;
                        else begin m_value = m_period; m_en = 0; end
                    end else begin
                        m_value = m_value + 1;
                    end
                end
            end
        end
        if (expire) m_exp = 1'b1;
        if (hit && we) begin
            case (off)
                8'h00: m_led    = merge(m_led, wd, be);
                8'h0C: m_period = merge(m_period, wd, be);
                8'h08: if (be[0]) begin
                    if (!en_old && wd[0]) begin m_value = 0; m_pre = 0; end
                    m_en = wd[0]; m_auto = wd[1]; m_ie = wd[2];
                end
                8'h14: if (be[0] && wd[0] && !expire) m_exp = 1'b0;
                default: ;
            endcase
        end
        m_sw2 = m_sw1;
        m_sw1 = gpio;
    endtask

    // ---------------- bus driving ----------------
    logic last_ack;

    task automatic do_cycle(input logic rst, input logic req, input logic we,
                            input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd);
        @(negedge clk);
        rst_n      = rst;
        bus.req    = req;
        bus.we     = we;
        bus.addr   = addr;
        bus.be     = be;
        bus.wdata  = wd;
        #1;
        last_ack = bus.ack;
        chk("ack", {31'd0, bus.ack}, {31'd0, req && (addr[31:8] == BASE[31:8])});
        @(posedge clk);
        model_step(rst, req, we, addr, be, wd, gpio_in);
        #1;
        chk("resp",    {31'd0, bus.resp}, {31'd0, m_resp});
        chk("rdata",   bus.rdata, m_rdata);
        chk("gpio_bo", gpio_out,  m_led);
        chk("irq",     {31'd0, irq}, {31'd0, m_exp & m_ie});
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] d);
        do_cycle(1'b1, 1'b1, 1'b1, BASE | {24'd0, off}, 4'hF, d);
    endtask

    task automatic rd(input logic [7:0] off);
        do_cycle(1'b1, 1'b1, 1'b0, BASE | {24'd0, off}, 4'hF, 32'd0);
    endtask

    task automatic idle();
        do_cycle(1'b1, 1'b0, 1'b0, 32'd0, 4'h0, 32'd0);
    endtask

    typedef struct {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        x_ack;
        logic        x_resp;
        logic [31:0] x_rdata;
    } vec_t;

    vec_t tbl[15];

    initial begin
        tbl[0]  = '{1, 0, 32'h8000_0000, 4'hF, 32'h0,         1, 1, 32'h0};
        tbl[1]  = '{1, 0, 32'h8000_0008, 4'hF, 32'h0,         1, 1, 32'h0};
        tbl[2]  = '{1, 0, 32'h8000_0014, 4'hF, 32'h0,         1, 1, 32'h0};
        tbl[3]  = '{1, 1, 32'h8000_0000, 4'h5, 32'hA5A5_A5A5, 1, 0, 32'h0};
        tbl[4]  = '{1, 0, 32'h8000_0000, 4'hF, 32'h0,         1, 1, 32'h00A5_00A5};
        tbl[5]  = '{1, 0, 32'h8000_0004, 4'hF, 32'h0,         1, 1, 32'h1234_5678};
        tbl[6]  = '{1, 0, 32'h8000_0100, 4'hF, 32'h0,         0, 0, 32'h0};
        tbl[7]  = '{1, 0, 32'h8000_0020, 4'hF, 32'h0,         1, 1, 32'h0};
        tbl[8]  = '{1, 1, 32'h8000_0003, 4'hF, 32'hFFFF_0000, 1, 0, 32'h0};
        tbl[9]  = '{1, 0, 32'h8000_0000, 4'hF, 32'h0,         1, 1, 32'hFFFF_0000};
        tbl[10] = '{1, 1, 32'h8000_0100, 4'hF, 32'h0,         0, 0, 32'h0};
        tbl[11] = '{1, 0, 32'h8000_0002, 4'hF, 32'h0,         1, 1, 32'hFFFF_0000};
        tbl[12] = '{0, 0, 32'h8000_0000, 4'hF, 32'h0,         0, 0, 32'h0};
        tbl[13] = '{1, 1, 32'h8000_0020, 4'hF, 32'h1234,      1, 0, 32'h0};
        tbl[14] = '{1, 0, 32'h8000_000C, 4'hF, 32'h0,         1, 1, 32'h0};

        rst_n = 1'b0;
        gpio_in = 32'h1234_5678;
        bus.req = 0; bus.we = 0; bus.addr = 0; bus.be = 0; bus.wdata = 0;

        do_cycle(1'b0, 1'b0, 1'b0, 32'd0, 4'h0, 32'd0);
        do_cycle(1'b0, 1'b0, 1'b0, 32'd0, 4'h0, 32'd0);
        chk("rst.resp",    {31'd0, bus.resp}, 32'd0);
        chk("rst.rdata",   bus.rdata, 32'd0);
        chk("rst.gpio_bo", gpio_out, 32'd0);
        chk("rst.irq",     {31'd0, irq}, 32'd0);

        // Register-access vectors with hand-derived expectations.
        for (int i = 0; i < 15; i++) begin
            do_cycle(1'b1, tbl[i].req, tbl[i].we, tbl[i].addr, tbl[i].be, tbl[i].wd);
            chk($sformatf("tbl%0d.ack", i),   {31'd0, last_ack}, {31'd0, tbl[i].x_ack});
            chk($sformatf("tbl%0d.resp", i),  {31'd0, bus.resp}, {31'd0, tbl[i].x_resp});
            chk($sformatf("tbl%0d.rdata", i), bus.rdata, tbl[i].x_rdata);
        end
        chk("led.gpio_bo", gpio_out, 32'hFFFF_0000);

        // Auto-reload: expiry 5 cycles after CTRL write, clear, re-expire 5 later.
        wr(8'h0C, 32'd5);
        wr(8'h08, 32'h7);
        for (int k = 1; k <= 5; k++) begin
            idle();
            chk($sformatf("auto.irq_c%0d", k), {31'd0, irq}, {31'd0, k == 5});
        end
        wr(8'h14, 32'h1);
        chk("auto.irq_clr", {31'd0, irq}, 32'd0);
        for (int k = 7; k <= 10; k++) begin
            idle();
            chk($sformatf("auto.irq_c%0d", k), {31'd0, irq}, {31'd0, k == 10});
        end

        // Clear lands on the exact expiry cycle: set must win.
        wr(8'h14, 32'h1);
        chk("coll.irq_pre", {31'd0, irq}, 32'd0);
        idle(); idle(); idle();
        wr(8'h14, 32'h1);
        chk("coll.irq", {31'd0, irq}, 32'd1);
        rd(8'h14);
        chk("coll.status", bus.rdata, 32'd1);

        // One-shot: VALUE parks at PERIOD and EN self-clears.
        wr(8'h08, 32'h0);
        wr(8'h14, 32'h1);
        wr(8'h0C, 32'd3);
        wr(8'h08, 32'h5);
        repeat (10) idle();
        rd(8'h10);
        chk("one.value", bus.rdata, 32'd3);
        rd(8'h08);
        chk("one.ctrl", bus.rdata, 32'h4);
        chk("one.irq", {31'd0, irq}, 32'd1);
        repeat (20) idle();
        rd(8'h10);
        chk("one.value_hold", bus.rdata, 32'd3);

        // Reset in the middle of a count, with a read presented in the reset cycle.
        wr(8'h0C, 32'd100);
        wr(8'h14, 32'h1);
        wr(8'h08, 32'h1);
        repeat (5) idle();
        rd(8'h10);
        chk("mid.value", bus.rdata, 32'd5);
        do_cycle(1'b0, 1'b1, 1'b0, BASE | 32'h10, 4'hF, 32'd0);
        chk("mid.resp_drop", {31'd0, bus.resp}, 32'd0);
        rd(8'h10);
        chk("mid.value_rst", bus.rdata, 32'd0);
        rd(8'h08);
        chk("mid.ctrl_rst", bus.rdata, 32'd0);

        // Randomised traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            logic [7:0]  off;
            logic [31:0] a, d;
            logic        rq, w, r;
            gpio_in = $urandom;
            case ($urandom_range(0, 7))
                0: off = 8'h00; 1: off = 8'h04; 2: off = 8'h08; 3: off = 8'h0C;
                4: off = 8'h10; 5: off = 8'h14; 6: off = 8'h20; default: off = 8'h08;
            endcase
            off = off | 8'($urandom_range(0, 3));
            a   = ($urandom_range(0, 7) == 0) ? (32'h8000_0100 | {24'd0, off})
                                               : (BASE | {24'd0, off});
            rq  = ($urandom_range(0, 3) != 0);
            w   = $urandom_range(0, 1) == 1;
            d   = $urandom;
            if ((off & 8'hFC) == 8'h0C) d = $urandom_range(0, 10);
            if ((off & 8'hFC) == 8'h08) d = $urandom_range(0, 7);
            r   = ($urandom_range(0, 299) != 0);
            do_cycle(r, rq, w, a, 4'($urandom), d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
